// File: rtl/movegen_piece_iterator.sv
// Colour piece stacks loaded from the serial board bus, plus an iterator that streams the side-to-play list.
// Optional MOVEGEN_ITER_COUNT_EN adds a piece_count output for the selected side.
module movegen_piece_iterator #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned SQUARES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_pos_valid,
  input  logic [3:0] in_pos_data,
  input  logic       in_pos_sop,
  input  logic       in_pos_eop,
  input  logic       in_wtp,
  input  logic       start,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic       done,
`ifdef MOVEGEN_ITER_COUNT_EN
  output logic [$clog2(DEPTH+1)-1:0] piece_count,
`endif
  output logic       overflow
);

  localparam int unsigned IW = $clog2(SQUARES);

  typedef enum logic {IDLE, ITER} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          sq_q, sq_d;
  logic                   loaded_q, loaded_d;
  logic                   ovf_q, ovf_d;
  logic                   sop_q, sop_d;
  logic                   done_q, done_d;
  logic [DEPTH-1:0][8:0]  w_slot_q, w_slot_d, b_slot_q, b_slot_d, it_slot_q, it_slot_d;
  logic [DEPTH-1:0]       w_occ_q, w_occ_d, b_occ_q, b_occ_d, it_occ_q, it_occ_d;
  logic [IW-1:0]          idx;
  logic [5:0]             idx6;
  logic [8:0]             rec;
  logic                   hs;

`ifdef MOVEGEN_ITER_COUNT_EN
  localparam int unsigned CW = $clog2(DEPTH+1);
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [CW-1:0] popcnt(input logic [DEPTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(DEPTH); i++) c = c + CW'(v[i]);
    return c;
  endfunction
`endif

  // Next-state for loader, colour stacks, iterator and FSM
  always_comb begin
    state_d   = state_q;
    sq_d      = sq_q;
    loaded_d  = loaded_q;
    ovf_d     = ovf_q;
    sop_d     = sop_q;
    done_d    = 1'b0;
    w_slot_d  = w_slot_q;
    w_occ_d   = w_occ_q;
    b_slot_d  = b_slot_q;
    b_occ_d   = b_occ_q;
    it_slot_d = it_slot_q;
    it_occ_d  = it_occ_q;
`ifdef MOVEGEN_ITER_COUNT_EN
    cnt_d     = cnt_q;
`endif
    idx  = in_pos_sop ? '0 : sq_q;
    idx6 = 6'(idx);
    rec  = {in_pos_data[2:0], idx6[5:3], idx6[2:0]};
    hs   = it_occ_q[0] && out_ready;

    if (in_pos_valid) begin
      if (in_pos_sop) begin
        sq_d     = IW'(1);
        w_slot_d = '0;
        w_occ_d  = '0;
        b_slot_d = '0;
        b_occ_d  = '0;
        loaded_d = 1'b0;
        ovf_d    = 1'b0;
      end else begin
        sq_d = (sq_q == IW'(SQUARES - 1)) ? '0 : sq_q + IW'(1);
      end
      if (in_pos_data[2:0] != 3'd0) begin
        if (in_pos_data[3]) begin
          if (w_occ_d[DEPTH-1]) ovf_d = 1'b1;
          else begin
            w_slot_d = {w_slot_d[DEPTH-2:0], rec};
            w_occ_d  = {w_occ_d[DEPTH-2:0], 1'b1};
          end
        end else begin
          if (b_occ_d[DEPTH-1]) ovf_d = 1'b1;
          else begin
            b_slot_d = {b_slot_d[DEPTH-2:0], rec};
            b_occ_d  = {b_occ_d[DEPTH-2:0], 1'b1};
          end
        end
      end
      if (in_pos_eop) loaded_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start && loaded_q && !in_pos_valid) begin
          // stacks are contiguous from slot 0, so slot 0 alone says empty/non-empty
          if (in_wtp ? w_occ_q[0] : b_occ_q[0]) begin
            state_d   = ITER;
            it_slot_d = in_wtp ? w_slot_q : b_slot_q;
            it_occ_d  = in_wtp ? w_occ_q : b_occ_q;
            sop_d     = 1'b1;
          end else begin
            done_d = 1'b1;
          end
`ifdef MOVEGEN_ITER_COUNT_EN
          cnt_d = popcnt(in_wtp ? w_occ_q : b_occ_q);
`endif
        end
      end
      ITER: begin
        if (in_pos_valid && in_pos_sop) begin
          state_d   = IDLE;
          it_slot_d = '0;
          it_occ_d  = '0;
          sop_d     = 1'b0;
        end else if (hs) begin
          it_slot_d = {9'd0, it_slot_q[DEPTH-1:1]};
          it_occ_d  = {1'b0, it_occ_q[DEPTH-1:1]};
          sop_d     = 1'b0;
          if (!it_occ_q[1]) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sq_q      <= '0;
      loaded_q  <= 1'b0;
      ovf_q     <= 1'b0;
      sop_q     <= 1'b0;
      done_q    <= 1'b0;
      w_slot_q  <= '0;
      w_occ_q   <= '0;
      b_slot_q  <= '0;
      b_occ_q   <= '0;
      it_slot_q <= '0;
      it_occ_q  <= '0;
`ifdef MOVEGEN_ITER_COUNT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sq_q      <= sq_d;
      loaded_q  <= loaded_d;
      ovf_q     <= ovf_d;
      sop_q     <= sop_d;
      done_q    <= done_d;
      w_slot_q  <= w_slot_d;
      w_occ_q   <= w_occ_d;
      b_slot_q  <= b_slot_d;
      b_occ_q   <= b_occ_d;
      it_slot_q <= it_slot_d;
      it_occ_q  <= it_occ_d;
`ifdef MOVEGEN_ITER_COUNT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign busy      = (state_q == ITER);
  assign out_valid = it_occ_q[0];
  assign out_data  = it_slot_q[0];
  assign out_sop   = sop_q;
  assign out_eop   = it_occ_q[0] & ~it_occ_q[1];
  assign done      = done_q;
  assign overflow  = ovf_q;
`ifdef MOVEGEN_ITER_COUNT_EN
  assign piece_count = cnt_q;
`endif

endmodule

// File: tb/tb_movegen_piece_iterator.sv
// Scoreboard bench for movegen_piece_iterator: board-level reference model, decoupled monitor.
module tb_movegen_piece_iterator;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_pos_valid, in_pos_sop, in_pos_eop, in_wtp, start, out_ready;
  logic [3:0] in_pos_data;
  logic       busy, out_valid, out_sop, out_eop, done, overflow;
  logic [8:0] out_data;

  always #5 clk = ~clk;

  movegen_piece_iterator #(.DEPTH(DEPTH), .SQUARES(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_pos_valid(in_pos_valid), .in_pos_data(in_pos_data),
    .in_pos_sop(in_pos_sop), .in_pos_eop(in_pos_eop), .in_wtp(in_wtp), .start(start),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .done(done), .overflow(overflow)
  );

  typedef struct packed {logic [8:0] data; logic sop; logic eop;} rec_t;
  rec_t       exp_q[$];
  logic [3:0] board[64];
  int         checks = 0, passes = 0, pops = 0;
  bit         pend_empty_done = 0, done_exp_next = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  // Monitor: compare every presented record against the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      bit de;
      de = done_exp_next;
      done_exp_next = pend_empty_done;
      pend_empty_done = 0;
      if (done || de) check("done", 32'(done), 32'(de));
      if (out_valid) begin
        check("busy_while_valid", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_record: actual data %0h required no record", out_data);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q[0].data));
          check("out_sop", 32'(out_sop), 32'(exp_q[0].sop));
          check("out_eop", 32'(out_eop), 32'(exp_q[0].eop));
          if (out_ready) begin
            if (exp_q[0].eop) done_exp_next = 1;
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_board();
    for (int s = 0; s < 64; s++) board[s] = 4'h0;
  endtask

  task automatic rand_board(input int nw, input int nb);
    int s;
    clear_board();
    for (int k = 0; k < nw + nb; k++) begin
      do s = int'($urandom_range(63)); while (board[s] != 4'h0);
      board[s] = {(k < nw) ? 1'b1 : 1'b0, 3'($urandom_range(6, 1))};
    end
  endtask

  task automatic start_board();
    int back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    clear_board();
    for (int f = 0; f < 8; f++) begin
      board[f]      = {1'b1, 3'(back[f])};
      board[8 + f]  = 4'b1001;
      board[48 + f] = 4'b0001;
      board[56 + f] = {1'b0, 3'(back[f])};
    end
  endtask

  task automatic load_board(input int from, input bit start_on_eop);
    for (int s = from; s < 64; s++) begin
      in_pos_valid = 1'b1;
      in_pos_data  = board[s];
      in_pos_sop   = (s == 0);
      in_pos_eop   = (s == 63);
      start        = start_on_eop && (s == 63);
      tick();
      in_pos_valid = 1'b0;
      in_pos_sop   = 1'b0;
      in_pos_eop   = 1'b0;
      start        = 1'b0;
      if ($urandom_range(3) == 0) tick();
    end
  endtask

  function automatic bit model_overflow();
    int nw = 0, nb = 0;
    for (int s = 0; s < 64; s++)
      if (board[s][2:0] != 3'd0) begin
        if (board[s][3]) nw++; else nb++;
      end
    return (nw > int'(DEPTH)) || (nb > int'(DEPTH));
  endfunction

  // Reference: first DEPTH pieces of the colour in square order, emitted highest square first
  task automatic do_start(input bit wtp);
    int   sqs[$];
    rec_t r;
    for (int s = 0; s < 64; s++)
      if (board[s][2:0] != 3'd0 && board[s][3] == wtp) sqs.push_back(s);
    while (sqs.size() > int'(DEPTH)) void'(sqs.pop_back());
    for (int i = sqs.size() - 1; i >= 0; i--) begin
      r.data = {board[sqs[i]][2:0], 6'(sqs[i])};
      r.sop  = (i == sqs.size() - 1);
      r.eop  = (i == 0);
      exp_q.push_back(r);
    end
    if (sqs.size() == 0) pend_empty_done = 1;
    in_wtp = wtp;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && n < budget) begin
      tick();
      n++;
    end
    check("iteration_completes", 32'(exp_q.size() != 0 || busy), 32'd0);
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_sop"}, 32'(out_sop), 32'd0);
    check({tag, "_out_eop"}, 32'(out_eop), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int p0, n;
    rst_n = 1'b0; in_pos_valid = 1'b0; in_pos_data = 4'h0; in_pos_sop = 1'b0;
    in_pos_eop = 1'b0; in_wtp = 1'b1; start = 1'b0; out_ready = 1'b1;
    do_reset();

    // start with nothing loaded must be ignored
    start = 1'b1; tick(); start = 1'b0; repeat (3) tick();

    // start position: white then black then white again, full throughput
    start_board();
    load_board(0, 1'b0);
    check("start_pos_overflow", 32'(overflow), 32'd0);
    p0 = pops;
    do_start(1'b1);
    repeat (17) tick();
    check("white_throughput_records", 32'(pops - p0), 32'd16);
    wait_idle(50);
    do_start(1'b0);
    wait_idle(50);
    do_start(1'b1);
    wait_idle(50);

    // start coincident with eop beat is ignored
    load_board(0, 1'b1);
    repeat (3) tick();
    check("start_on_eop_ignored", 32'(busy), 32'd0);

    // overflow: more white pieces than stack slots
    rand_board(DEPTH + 4, 5);
    load_board(0, 1'b0);
    check("overflow_set", 32'(overflow), 32'd1);
    do_start(1'b1);
    wait_idle(60);

    // stall pattern on a 3-piece board
    rand_board(3, 2);
    load_board(0, 1'b0);
    p0 = pops;
    do_start(1'b1);
    begin
      bit pat[5] = '{1, 0, 0, 1, 1};
      for (int i = 0; i < 5; i++) begin
        out_ready = pat[i];
        tick();
      end
    end
    out_ready = 1'b1;
    wait_idle(20);
    check("stall_handshakes", 32'(pops - p0), 32'd3);

    // empty side: done the cycle after start, no records
    rand_board(4, 0);
    load_board(0, 1'b0);
    do_start(1'b0);
    repeat (4) tick();

    // abort by a new board load after two records
    start_board();
    load_board(0, 1'b0);
    p0 = pops;
    do_start(1'b1);
    n = 0;
    while (pops < p0 + 2 && n < 20) begin tick(); n++; end
    out_ready    = 1'b0;
    in_pos_valid = 1'b1; in_pos_data = board[0]; in_pos_sop = 1'b1;
    tick();
    in_pos_valid = 1'b0; in_pos_sop = 1'b0;
    exp_q.delete();
    check("abort_records", 32'(pops - p0), 32'd2);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    load_board(1, 1'b0);
    do_start(1'b0);
    wait_idle(50);

    // asynchronous reset mid-iteration
    do_start(1'b1);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    done_exp_next = 0;
    pend_empty_done = 0;
    tick();
    rst_n = 1'b1;
    tick();

    // randomized boards with random backpressure
    for (int it = 0; it < 6; it++) begin
      rand_board(int'($urandom_range(20)), int'($urandom_range(20)));
      load_board(0, 1'b0);
      check("rand_overflow", 32'(overflow), 32'(model_overflow()));
      for (int side = 0; side < 2; side++) begin
        do_start(side[0]);
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
          out_ready = ($urandom_range(2) != 0);
          tick();
          n++;
        end
        out_ready = 1'b1;
        wait_idle(50);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual timeout required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/movegen_piece_iterator.md
# movegen_piece_iterator

Parametrised successor to the board-level piece stacks in the move generator. It captures the white and black piece lists from the serial `in_pos` board-load bus into two push-down stacks of configurable depth. On `start` it snapshots the side-to-play list into an iterator stack. It then emits one `{piece, rank, file}` record per piece over a valid/ready stream with sop/eop framing, and sits between the serial board loader and the per-piece move emitters.

## Interface
- `DEPTH`, 16, slots per colour stack (max pieces per side held), ≥2
- `SQUARES`, 64, serial beats per board load; square index width `IW = $clog2(SQUARES)` = 6
- `clk` in 1 — single clock, all logic rising-edge
- `rst_n` in 1 — asynchronous active-low reset
- `in_pos_valid` in 1 — serial board beat valid
- `in_pos_data` in 4 — `{colour(1 = white), piece[2:0]}`; `piece = 0` is an empty square
- `in_pos_sop` in 1 — first square (index 0) of a board load
- `in_pos_eop` in 1 — last square of a board load
- `in_wtp` in 1 — 1 = white to play, sampled with `start`
- `start` in 1 — single-cycle request to begin iteration
- `busy` out 1 — iteration in progress
- `out_valid` out 1 — record available
- `out_ready` in 1 — consumer accepts record
- `out_data` out 9 — `{piece[2:0], rank[2:0], file[2:0]}`
- `out_sop` out 1 — first record of an iteration
- `out_eop` out 1 — last record of an iteration
- `done` out 1 — one-cycle pulse when an iteration completes
- `overflow` out 1 — sticky: a piece was dropped because its colour stack was full

## Operation
- Square counter `sq`:
  - Set to 1 on a valid sop beat (that beat is square 0).
  - Otherwise increments on each valid beat, wrapping mod `SQUARES`.
  - Beat square index is `in_pos_sop ? 0 : sq`; `rank = idx[5:3]`, `file = idx[2:0]`.
- Valid sop beat:
  - Clears both colour stacks, `loaded` and `overflow` in the same cycle.
  - The sop beat's own piece, if any, is then pushed into the cleared stack.
- Push rule:
  - A valid beat with nonzero piece pushes `{piece, rank, file}` into slot 0 of its colour's stack; occupied slots shift down one.
  - If all `DEPTH` slots are occupied, the stack is unchanged and `overflow` is set.
  - Empty squares change nothing.
- A valid eop beat sets `loaded`.
- States:
  - IDLE → ITER: on `start && loaded && !in_pos_valid`. Copies the full stack for `in_wtp` (slots plus occupancy bits) into the iterator stack. Colour stacks are untouched, so `start` may be repeated for the same board.
  - IDLE → IDLE with `done` pulse: `start` accepted but the selected stack is empty. No records are emitted.
  - `start` in any other condition is ignored.
  - ITER: `out_valid` = occupancy of iterator slot 0; `out_data` = slot 0.
  - ITER: on `out_valid && out_ready`, the iterator shifts up one slot (vacated bottom becomes empty).
  - `out_eop` = slot 0 occupied and slot 1 empty.
  - `out_sop` is high for the first record until it is accepted.
  - ITER → IDLE: the handshake on the eop record, with a `done` pulse.
- Emission order is reverse of load order, i.e. descending square index.
- Abort: a valid sop beat while in ITER returns the block to IDLE next cycle. The iterator is cleared, `out_valid` drops, and no `done` pulse is produced.
- `busy` = (state == ITER).

## Timing
- Reset values: state IDLE, all stacks and occupancy bits empty, `sq` = 0, `loaded` = 0.
- Reset outputs: `busy`, `out_valid`, `out_sop`, `out_eop`, `done` and `overflow` are 0; `out_data` = 0.
- Push latency: a piece on load beat N is in slot 0 at the next edge.
- `start` at edge T gives `out_valid` high after edge T (first record in cycle T+1).
- Throughput: one record per cycle while `out_ready` = 1.
- `out_data`, `out_sop` and `out_eop` hold stable while `out_valid && !out_ready`.
- `done` is high in the cycle after the final handshake edge.
- `start` while `busy` is ignored.
- Simultaneous eop beat and `start`: `start` is ignored because `in_pos_valid` is high.

## Configuration
- `MOVEGEN_ITER_COUNT_EN` defined:
  - Adds output `piece_count`, width `$clog2(DEPTH+1)`, reset 0.
  - Loaded with the number of occupied slots of the selected stack in the cycle `start` is accepted.
  - Holds until the next accepted `start`.
- `MOVEGEN_ITER_COUNT_EN` undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Start position, 64 beats with sop/eop, `in_wtp` = 1, `start`, `out_ready` = 1:
  - 16 records in consecutive cycles.
  - First record is piece of square 15 = rank 1, file 7; `out_sop` = 1.
  - Last record is square 0; `out_eop` = 1.
  - `done` pulses once; `overflow` = 0; `piece_count` = 16 if enabled.
- Same board, `in_wtp` = 0: 16 black records; first is square 63 (rank 7, file 7), last is square 48; the white stack is unchanged, shown by a repeat white start giving identical output.
- `DEPTH` = 4, board with 6 white pieces:
  - `overflow` = 1.
  - A white start emits only the first 4 loaded squares, in descending order.
- `out_ready` toggled 1,0,0,1 on a 3-piece board: `out_data` is held across stalls, exactly 3 handshakes occur, and `done` follows the eop accept.
- Board with no black pieces, `in_wtp` = 0, `start`: `out_valid` never rises and `done` pulses the cycle after `start`.
- Mid-iteration sop beat after 2 of 16 records: `out_valid` = 0 next cycle, no `done`, and `busy` = 0. Separately, asserting `rst_n` = 0 mid-iteration immediately gives all outputs 0.
